// File: rtl/dll_ack_nak_sched.sv
// Data-link-layer Ack/Nak DLLP scheduler.
// Collects "good TLP" notifications and Nak requests from the RX sequence
// checker, decides when an Ack or Nak DLLP must be sent, requests a DLLP slot
// from the TX arbiter and emits the DLLP body (without CRC16) for one cycle.
//
// Ports:
//   clk               sole clock, rising edge
//   rst               asynchronous active-low reset
//   DL_Down           link down, synchronous flush of all state and outputs
//   schedule_ack      pulse: good TLP accepted, an Ack is owed
//   NAK_SCHEDULED     level: a Nak is required
//   req_seq_num[11:0] sequence number to report, valid with the two above
//   ack_nak_time_out  pulse from the Ack/Nak latency timer
//   dllp_gnt          TX arbiter grant for the DLLP slot
//   dllp_req          DLLP slot request
//   dllp_o[31:0]      DLLP body {type, 8'h00, 4'h0, seq}, zero when not valid
//   dllp_vld          dllp_o valid (one cycle)
//   initiate_ack      pulse in the Ack emit cycle
//   initiate_nak      pulse in the Nak emit cycle
//   nak_outstanding   a Nak was sent and no Ack has been sent since
module dll_ack_nak_sched #(
  parameter logic [7:0]  ACK_TYPE     = 8'h00,
  parameter logic [7:0]  NAK_TYPE     = 8'h10,
  parameter int unsigned ACK_COALESCE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DL_Down,
  input  logic        schedule_ack,
  input  logic        NAK_SCHEDULED,
  input  logic [11:0] req_seq_num,
  input  logic        ack_nak_time_out,
  input  logic        dllp_gnt,
  output logic        dllp_req,
  output logic [31:0] dllp_o,
  output logic        dllp_vld,
  output logic        initiate_ack,
  output logic        initiate_nak,
  output logic        nak_outstanding
);

  localparam int unsigned SEQ_W  = 12;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DLLP_W = 32;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] COAL_THR = CNT_W'(ACK_COALESCE);

  // Ack/Nak DLLP body as it leaves this block (CRC appended downstream).
  typedef struct packed {
    logic [7:0]       dllp_type;
    logic [7:0]       rsvd_hi;
    logic [3:0]       rsvd_lo;
    logic [SEQ_W-1:0] seq;
  } dllp_body_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ_NAK = 2'd1,
    REQ_ACK = 2'd2,
    EMIT    = 2'd3
  } state_t;

  state_t            state;
  state_t            next_state;

  logic [SEQ_W-1:0]  seq_q;
  logic [SEQ_W-1:0]  seq_d;
  logic              ack_pend;
  logic              ack_pend_d;
  logic [CNT_W-1:0]  ack_cnt;
  logic [CNT_W-1:0]  ack_cnt_d;
  logic              nak_out_d;
  logic              emit_nak;
  logic              emit_nak_d;

  logic              dllp_req_d;
  logic              dllp_vld_d;
  logic              initiate_ack_d;
  logic              initiate_nak_d;
  dllp_body_t        body_d;

  logic              nak_cond;
  logic              ack_cond;

  // A new Nak is only worth sending if the previous one has been answered by an Ack.
  assign nak_cond = NAK_SCHEDULED && !nak_outstanding;
  assign ack_cond = ack_pend && (ack_nak_time_out || (ack_cnt >= COAL_THR));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state, bookkeeping and next registered output values.
  always_comb begin
    next_state     = state;
    seq_d          = (schedule_ack || NAK_SCHEDULED) ? req_seq_num : seq_q;
    ack_pend_d     = ack_pend || schedule_ack;
    ack_cnt_d      = (schedule_ack && (ack_cnt != CNT_MAX)) ? (ack_cnt + CNT_W'(1)) : ack_cnt;
    nak_out_d      = nak_outstanding;
    emit_nak_d     = emit_nak;
    dllp_req_d     = 1'b0;
    dllp_vld_d     = 1'b0;
    initiate_ack_d = 1'b0;
    initiate_nak_d = 1'b0;
    body_d         = '0;

    case (state)
      IDLE: begin
        if (nak_cond) begin
          next_state = REQ_NAK;
          // The Nak supersedes an Ack that became due in the same cycle.
          if (ack_cond) begin
            ack_pend_d = 1'b0;
            ack_cnt_d  = '0;
          end
        end else if (ack_cond) begin
          next_state = REQ_ACK;
        end
      end
      REQ_NAK: begin
        if (dllp_gnt) begin
          next_state = EMIT;
          emit_nak_d = 1'b1;
        end
      end
      REQ_ACK: begin
        if (dllp_gnt) begin
          next_state = EMIT;
          emit_nak_d = 1'b0;
        end else if (nak_cond) begin
          next_state = REQ_NAK;
        end
      end
      EMIT: begin
        next_state = IDLE;
        if (emit_nak) begin
          nak_out_d = 1'b1;
        end else begin
          // An ack request landing in the emit cycle is not covered by this DLLP.
          nak_out_d  = 1'b0;
          ack_pend_d = schedule_ack;
          ack_cnt_d  = schedule_ack ? CNT_W'(1) : '0;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase

    if (DL_Down) begin
      next_state = IDLE;
      seq_d      = '0;
      ack_pend_d = 1'b0;
      ack_cnt_d  = '0;
      nak_out_d  = 1'b0;
      emit_nak_d = 1'b0;
    end

    dllp_req_d = (next_state == REQ_NAK) || (next_state == REQ_ACK);
    dllp_vld_d = (next_state == EMIT);
    if (dllp_vld_d) begin
      // seq_d so a number arriving in the grant cycle is still reported.
      body_d.dllp_type = emit_nak_d ? NAK_TYPE : ACK_TYPE;
      body_d.seq       = seq_d;
      initiate_nak_d   = emit_nak_d;
      initiate_ack_d   = !emit_nak_d;
    end
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq_q           <= '0;
      ack_pend        <= 1'b0;
      ack_cnt         <= '0;
      nak_outstanding <= 1'b0;
      emit_nak        <= 1'b0;
      dllp_req        <= 1'b0;
      dllp_vld        <= 1'b0;
      dllp_o          <= '0;
      initiate_ack    <= 1'b0;
      initiate_nak    <= 1'b0;
    end else begin
      seq_q           <= seq_d;
      ack_pend        <= ack_pend_d;
      ack_cnt         <= ack_cnt_d;
      nak_outstanding <= nak_out_d;
      emit_nak        <= emit_nak_d;
      dllp_req        <= dllp_req_d;
      dllp_vld        <= dllp_vld_d;
      dllp_o          <= DLLP_W'(body_d);
      initiate_ack    <= initiate_ack_d;
      initiate_nak    <= initiate_nak_d;
    end
  end

endmodule
